// File: rtl/rtmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rtmem_arbiter
// Description : Three-way arbiter for the single-port routing-table RAM
//               (neighbour ID, battery, Q-value, cluster ID, sink ID arrays).
//               Requester 0 = Q-table update FSM, 1 = best-hop selector,
//               2 = host/debug reader. One owner at a time; an owner can hold
//               a locked burst of up to MAX_HOLD accesses.
//               Optional macro RTMEM_ARB_RR_EN selects round-robin winner
//               selection instead of fixed priority 0 > 1 > 2.
// Ports       : clk, nrst            - clock, async active-low reset
//               req/lock/wr [2:0]    - per-requester request, burst lock, write
//               addr_bus, wdata_bus  - requester k at [k*AW +: AW] / [k*DW +: DW]
//               gnt, rvalid [2:0]    - registered one-hot grant / read valid
//               rdata                - registered shared read data
//               mem_en/mem_wr/mem_addr/mem_wdata - RAM request (combinational)
//               mem_rdata            - RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module rtmem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [2:0]      req,
  input  logic [2:0]      lock,
  input  logic [2:0]      wr,
  input  logic [3*AW-1:0] addr_bus,
  input  logic [3*DW-1:0] wdata_bus,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_busy   = 1'b1;
  // Last counter value at which a locked owner may still continue.
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  logic [0:0]    r_state,  w_state_nxt;
  logic [1:0]    r_owner,  w_owner_nxt;
  logic [7:0]    r_hold,   w_hold_nxt;
  logic [2:0]    r_gnt,    w_gnt_nxt;
  logic [2:0]    r_rvalid, w_rvalid_nxt;
  logic [DW-1:0] r_rdata,  w_rdata_nxt;

  logic          w_own_req;
  logic          w_own_lock;
  logic          w_own_wr;
  logic [AW-1:0] w_own_addr;
  logic [DW-1:0] w_own_wdata;
  logic          w_access;
  logic [1:0]    w_winner;

  function automatic logic [2:0] f_onehot(input logic [1:0] k);
    return 3'(3'b001 << k);
  endfunction

  // First requesting index in the order a, b, c (only meaningful if req != 0).
  function automatic logic [1:0] f_pick(input logic [2:0] r, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
    if (r[a])      return a;
    else if (r[b]) return b;
    else           return c;
  endfunction

  // Owner's request slice; everything from non-owners is ignored.
  always_comb begin
    w_own_req   = 1'b0;
    w_own_lock  = 1'b0;
    w_own_wr    = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    case (r_owner)
      2'd0: begin
        w_own_req   = req[0];
        w_own_lock  = lock[0];
        w_own_wr    = wr[0];
        w_own_addr  = addr_bus[0*AW +: AW];
        w_own_wdata = wdata_bus[0*DW +: DW];
      end
      2'd1: begin
        w_own_req   = req[1];
        w_own_lock  = lock[1];
        w_own_wr    = wr[1];
        w_own_addr  = addr_bus[1*AW +: AW];
        w_own_wdata = wdata_bus[1*DW +: DW];
      end
      2'd2: begin
        w_own_req   = req[2];
        w_own_lock  = lock[2];
        w_own_wr    = wr[2];
        w_own_addr  = addr_bus[2*AW +: AW];
        w_own_wdata = wdata_bus[2*DW +: DW];
      end
      default: begin
        w_own_req   = 1'b0;
      end
    endcase
  end

  // The grant bit of the owner is set exactly while BUSY.
  assign w_access = (r_state == c_st_busy) && w_own_req;

`ifdef RTMEM_ARB_RR_EN
  logic [1:0] r_last_owner, w_last_nxt;
  logic [1:0] w_start;

  assign w_start = (r_last_owner == 2'd2) ? 2'd0 : (r_last_owner + 2'd1);

  always_comb begin
    case (w_start)
      2'd0:    w_winner = f_pick(req, 2'd0, 2'd1, 2'd2);
      2'd1:    w_winner = f_pick(req, 2'd1, 2'd2, 2'd0);
      default: w_winner = f_pick(req, 2'd2, 2'd0, 2'd1);
    endcase
  end
`else
  assign w_winner = f_pick(req, 2'd0, 2'd1, 2'd2);
`endif

  // State register (also holds the registered response outputs).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= c_st_idle;
      r_owner  <= 2'd0;
      r_hold   <= 8'd0;
      r_gnt    <= 3'b000;
      r_rvalid <= 3'b000;
      r_rdata  <= '0;
`ifdef RTMEM_ARB_RR_EN
      // Starting at 2 makes requester 0 the first winner.
      r_last_owner <= 2'd2;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_hold   <= w_hold_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rdata  <= w_rdata_nxt;
`ifdef RTMEM_ARB_RR_EN
      r_last_owner <= w_last_nxt;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_hold_nxt   = r_hold;
    w_gnt_nxt    = r_gnt;
    w_rvalid_nxt = 3'b000;
    w_rdata_nxt  = r_rdata;
`ifdef RTMEM_ARB_RR_EN
    w_last_nxt   = r_last_owner;
`endif
    case (r_state)
      c_st_idle: begin
        if (|req) begin
          w_state_nxt = c_st_busy;
          w_owner_nxt = w_winner;
          w_gnt_nxt   = f_onehot(w_winner);
          w_hold_nxt  = 8'd0;
`ifdef RTMEM_ARB_RR_EN
          w_last_nxt  = w_winner;
`endif
        end else begin
          w_gnt_nxt = 3'b000;
        end
      end
      default: begin
        if (w_own_req && w_own_lock && (r_hold < c_hold_last)) begin
          w_hold_nxt = r_hold + 8'd1;
        end else begin
          // Unlocked access, forced release, or owner gave up the request.
          w_state_nxt = c_st_idle;
          w_gnt_nxt   = 3'b000;
          w_hold_nxt  = 8'd0;
        end
      end
    endcase
    // Read response follows the access by one edge, even after release.
    if (w_access && !w_own_wr) begin
      w_rvalid_nxt = f_onehot(r_owner);
      w_rdata_nxt  = mem_rdata;
    end
  end

  // Output logic: RAM request is driven only during an access cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_access) begin
      mem_en    = 1'b1;
      mem_wr    = w_own_wr;
      mem_addr  = w_own_addr;
      mem_wdata = w_own_wdata;
    end
  end

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rtmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtmem_arbiter
// Description : Directed table-driven bench for rtmem_arbiter (MAX_HOLD=4).
//               Contention expectations follow RTMEM_ARB_RR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtmem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  req, lock, wr;
  logic [47:0] addr_bus, wdata_bus;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // RAM model: read data is a fixed function of the address (0x0010 -> 0xBEEF).
  assign mem_rdata = mem_addr ^ 16'hBEFF;

  rtmem_arbiter #(.AW(16), .DW(16), .MAX_HOLD(4)) dut (
    .clk(clk), .nrst(nrst), .req(req), .lock(lock), .wr(wr),
    .addr_bus(addr_bus), .wdata_bus(wdata_bus), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [2:0]  req, lock, wr;
    logic [15:0] a0, d0;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        en, mwr;
    logic [15:0] maddr, mwdata;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w,
                              input logic [15:0] a0, input logic [15:0] d0,
                              input logic [2:0] g, input logic [2:0] rv, input logic [15:0] rd,
                              input logic en, input logic mw, input logic [15:0] ma,
                              input logic [15:0] md);
    vec_t v;
    v.req = rq; v.lock = lk; v.wr = w; v.a0 = a0; v.d0 = d0;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.en = en; v.mwr = mw;
    v.maddr = ma; v.mwdata = md;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt"},    {29'd0, gnt},    32'd0);
    chk({tag, "_rvalid"}, {29'd0, rvalid}, 32'd0);
    chk({tag, "_rdata"},  {16'd0, rdata},  32'd0);
    chk({tag, "_mem"},    {mem_en, mem_wr, mem_addr, mem_wdata}, 34'd0);
  endtask

  vec_t tbl[23];
  int   exp_k[4];

  initial begin
`ifdef RTMEM_ARB_RR_EN
    exp_k = '{0, 1, 2, 0};
`else
    exp_k = '{0, 0, 0, 0};
`endif
    //                req     lock    wr      a0        d0        gnt     rvalid  rdata     en    mwr   maddr     mwdata
    // single read
    tbl[0]  = mk(3'b001, 3'b000, 3'b000, 16'h0010, 16'h1111, 3'b000, 3'b000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[1]  = mk(3'b001, 3'b000, 3'b000, 16'h0010, 16'h1111, 3'b001, 3'b000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h1111);
    tbl[2]  = mk(3'b000, 3'b000, 3'b000, 16'h0010, 16'h1111, 3'b000, 3'b001, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[3]  = mk(3'b000, 3'b000, 3'b000, 16'h0010, 16'h1111, 3'b000, 3'b000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    // locked write burst by 0 while 1 waits; 1 then reads with 0's lock/wr ignored
    tbl[4]  = mk(3'b011, 3'b001, 3'b001, 16'h0002, 16'hAAA1, 3'b000, 3'b000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[5]  = mk(3'b011, 3'b001, 3'b001, 16'h0002, 16'hAAA1, 3'b001, 3'b000, 16'hBEEF, 1'b1, 1'b1, 16'h0002, 16'hAAA1);
    tbl[6]  = mk(3'b011, 3'b001, 3'b001, 16'h0004, 16'hAAA2, 3'b001, 3'b000, 16'hBEEF, 1'b1, 1'b1, 16'h0004, 16'hAAA2);
    tbl[7]  = mk(3'b011, 3'b000, 3'b001, 16'h0006, 16'hAAA3, 3'b001, 3'b000, 16'hBEEF, 1'b1, 1'b1, 16'h0006, 16'hAAA3);
    tbl[8]  = mk(3'b010, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b000, 3'b000, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[9]  = mk(3'b010, 3'b001, 3'b001, 16'h0006, 16'hAAA3, 3'b010, 3'b000, 16'hBEEF, 1'b1, 1'b0, 16'h0100, 16'hBBB1);
    tbl[10] = mk(3'b000, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b000, 3'b010, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    // owner 1 drops req in its grant cycle
    tbl[11] = mk(3'b010, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b000, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[12] = mk(3'b000, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b010, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[13] = mk(3'b000, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b000, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    // forced release of requester 2 after 4 locked writes, then regrant
    tbl[14] = mk(3'b100, 3'b100, 3'b100, 16'h0006, 16'hAAA3, 3'b000, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[15] = mk(3'b100, 3'b100, 3'b100, 16'h0006, 16'hAAA3, 3'b100, 3'b000, 16'hBFFF, 1'b1, 1'b1, 16'h0200, 16'hCCC1);
    tbl[16] = tbl[15];
    tbl[17] = tbl[15];
    tbl[18] = tbl[15];
    tbl[19] = mk(3'b100, 3'b100, 3'b100, 16'h0006, 16'hAAA3, 3'b000, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[20] = tbl[15];
    tbl[21] = mk(3'b000, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b100, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tbl[22] = mk(3'b000, 3'b000, 3'b000, 16'h0006, 16'hAAA3, 3'b000, 3'b000, 16'hBFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);

    nrst = 1'b0; req = '0; lock = '0; wr = '0; addr_bus = '0; wdata_bus = '0;
    repeat (2) @(negedge clk);
    #1 chk_idle_zero("reset");
    @(negedge clk);
    nrst = 1'b1;

    // Each row: inputs applied for one cycle, outputs sampled in that cycle.
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      req = tbl[i].req; lock = tbl[i].lock; wr = tbl[i].wr;
      addr_bus  = {16'h0200, 16'h0100, tbl[i].a0};
      wdata_bus = {16'hCCC1, 16'hBBB1, tbl[i].d0};
      #1;
      chk($sformatf("row%0d_gnt", i),    {29'd0, gnt},    {29'd0, tbl[i].gnt});
      chk($sformatf("row%0d_rvalid", i), {29'd0, rvalid}, {29'd0, tbl[i].rvalid});
      chk($sformatf("row%0d_rdata", i),  {16'd0, rdata},  {16'd0, tbl[i].rdata});
      chk($sformatf("row%0d_en_wr", i),  {30'd0, mem_en, mem_wr}, {30'd0, tbl[i].en, tbl[i].mwr});
      chk($sformatf("row%0d_addr", i),   {16'd0, mem_addr},  {16'd0, tbl[i].maddr});
      chk($sformatf("row%0d_wdata", i),  {16'd0, mem_wdata}, {16'd0, tbl[i].mwdata});
    end

    // Contention: all three request single reads continuously.
    begin
      int prev;
      logic [15:0] ea;
      prev = 0;
      for (int g = 0; g < 4; g++) begin
        @(negedge clk);
        if (g == 0) begin
          req = 3'b111; lock = 3'b000; wr = 3'b000;
          addr_bus = {16'h3000, 16'h2000, 16'h1000};
        end
        #1;
        chk($sformatf("cont%0d_idle_gnt", g), {29'd0, gnt}, 32'd0);
        if (g > 0) begin
          ea = 16'(16'h1000 * (prev + 1));
          chk($sformatf("cont%0d_rvalid", g), {29'd0, rvalid}, {29'd0, 3'(3'b001 << prev)});
          chk($sformatf("cont%0d_rdata", g), {16'd0, rdata}, {16'd0, ea ^ 16'hBEFF});
        end
        @(negedge clk);
        #1;
        ea = 16'(16'h1000 * (exp_k[g] + 1));
        chk($sformatf("cont%0d_gnt", g), {29'd0, gnt}, {29'd0, 3'(3'b001 << exp_k[g])});
        chk($sformatf("cont%0d_addr", g), {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, ea});
        prev = exp_k[g];
      end
      @(negedge clk);
      req = 3'b000;
      #1;
      ea = 16'(16'h1000 * (prev + 1));
      chk("cont_end_gnt", {29'd0, gnt}, 32'd0);
      chk("cont_end_rvalid", {29'd0, rvalid}, {29'd0, 3'(3'b001 << prev)});
      chk("cont_end_rdata", {16'd0, rdata}, {16'd0, ea ^ 16'hBEFF});
    end

    // Reset in the cycle after a read access discards the response.
    @(negedge clk);
    req = 3'b001; wr = 3'b000; lock = 3'b000;
    addr_bus = {16'h0200, 16'h0100, 16'h0010};
    #1 chk("rst_rd_idle", {29'd0, gnt}, 32'd0);
    @(negedge clk);
    #1 chk("rst_rd_access", {28'd0, mem_en, gnt}, {28'd0, 1'b1, 3'b001});
    @(negedge clk);
    req = 3'b000;
    #1 chk("rst_rd_rvalid_pre", {29'd0, rvalid}, 32'd1);
    nrst = 1'b0;
    #1 chk_idle_zero("rst_mid");
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk($sformatf("rst_after%0d", c), {26'd0, gnt, rvalid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
